// File: rtl/pulse_counter_mc_pkg.sv
// Shared encodings for the multi-channel pulse counter: reporter states,
// edge-polarity constants and the edge-match helper used by every channel.
package pulse_counter_mc_pkg;

    typedef enum logic [1:0] {
        S_LOCK = 2'd0,
        S_IDLE = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } rep_state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    function automatic logic edge_hit(input logic edge_sel, input logic prev, input logic cur);
        return (edge_sel == EDGE_FALL) ? (prev & ~cur) : (~prev & cur);
    endfunction

endpackage

// File: rtl/pulse_counter_mc_channel.sv
// One pulse channel: optional sync+debounce (PULSE_COUNTER_MC_DEBOUNCE_EN), edge detect,
// counter with wrap/saturate, sticky overflow and a report-pending flag.
module pulse_counter_mc_channel
    import pulse_counter_mc_pkg::*;
#(
    parameter int DATAWIDTH_BUS   = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pulse_in,
    input  logic                     clear_in,
    input  logic                     edge_sel,
    input  logic                     saturate,
    input  logic                     lock,
    input  logic                     pend_clr,
    output logic [DATAWIDTH_BUS-1:0] count_out,
    output logic                     overflow_out,
    output logic                     pending_out
);

    localparam logic [DATAWIDTH_BUS-1:0] CNT_MAX = '1;

    logic level;

`ifdef PULSE_COUNTER_MC_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic           sync1_q, sync2_q, filt_q, filt_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;

    // Filtered level flips only once the synchronised input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= pulse_in;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = filt_q;
`else
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    assign level = pulse_in;
`endif

    logic                     prev_q;
    logic [DATAWIDTH_BUS-1:0] count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     pend_q, pend_d;
    logic                     hit;

    assign hit = edge_hit(edge_sel, prev_q, level);

    // A same-cycle edge re-arms pending after the reporter's clear.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q & ~pend_clr;
        if (clear_in) begin
            count_d = '0;
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
        end else if (hit && !lock) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + DATAWIDTH_BUS'(1);
                pend_d  = 1'b1;
            end else if (saturate) begin
                ovf_d = 1'b1;
            end else begin
                count_d = '0;
                ovf_d   = 1'b1;
                pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            prev_q  <= level;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign count_out    = count_q;
    assign overflow_out = ovf_q;
    assign pending_out  = pend_q;

endmodule

// File: rtl/pulse_counter_mc.sv
// Multi-channel edge counter with round-robin reporting to a UART TX (newData strobe gated by txBusy).
// Optional input debounce via PULSE_COUNTER_MC_DEBOUNCE_EN; all outputs registered.
module pulse_counter_mc
    import pulse_counter_mc_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATAWIDTH_BUS   = 8,
    parameter int CHAN_ID_WIDTH   = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STATE_SIZE      = 2
) (
    input  logic                                  PULSE_COUNTER_MC_CLOCK_50,
    input  logic                                  PULSE_COUNTER_MC_RESET_InLow,
    input  logic [NUM_CHANNELS-1:0]               PULSE_COUNTER_MC_PULSE_InHigh,
    input  logic [NUM_CHANNELS-1:0]               PULSE_COUNTER_MC_CLEAR_InHigh,
    input  logic                                  PULSE_COUNTER_MC_EDGE_SEL_In,
    input  logic                                  PULSE_COUNTER_MC_SATURATE_InHigh,
    input  logic                                  PULSE_COUNTER_MC_LOCK_InHigh,
    input  logic                                  PULSE_COUNTER_MC_txBusy_InHigh,
    output logic                                  PULSE_COUNTER_MC_newData_Out,
    output logic [DATAWIDTH_BUS-1:0]              PULSE_COUNTER_MC_data_Out,
    output logic [CHAN_ID_WIDTH-1:0]              PULSE_COUNTER_MC_channel_Out,
    output logic [NUM_CHANNELS-1:0]               PULSE_COUNTER_MC_overflow_Out,
    output logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] PULSE_COUNTER_MC_dataCounter_Out
);

    if (CHAN_ID_WIDTH < 1 || (1 << CHAN_ID_WIDTH) < NUM_CHANNELS) begin : g_bad_id_width
        $error("CHAN_ID_WIDTH too narrow for NUM_CHANNELS");
    end
    if (STATE_SIZE != 2) begin : g_bad_state_size
        $error("reporter state encoding is 2 bits wide");
    end

    logic                                  clk, rst_n, lock, busy;
    logic [NUM_CHANNELS-1:0]               pending, overflow, pend_clr;
    logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] counts;

    assign clk   = PULSE_COUNTER_MC_CLOCK_50;
    assign rst_n = PULSE_COUNTER_MC_RESET_InLow;
    assign lock  = PULSE_COUNTER_MC_LOCK_InHigh;
    assign busy  = PULSE_COUNTER_MC_txBusy_InHigh;

    rep_state_t               state_q, state_d;
    logic [CHAN_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [CHAN_ID_WIDTH-1:0] grant_q, grant_d;
    logic                     wait_q, wait_d;
    logic                     nd_q, nd_d;
    logic [DATAWIDTH_BUS-1:0] data_q, data_d;
    logic [CHAN_ID_WIDTH-1:0] chan_q, chan_d;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        assign pend_clr[g] = (state_q == S_SEND) && (grant_q == CHAN_ID_WIDTH'(g));

        pulse_counter_mc_channel #(
            .DATAWIDTH_BUS  (DATAWIDTH_BUS),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .pulse_in    (PULSE_COUNTER_MC_PULSE_InHigh[g]),
            .clear_in    (PULSE_COUNTER_MC_CLEAR_InHigh[g]),
            .edge_sel    (PULSE_COUNTER_MC_EDGE_SEL_In),
            .saturate    (PULSE_COUNTER_MC_SATURATE_InHigh),
            .lock        (lock),
            .pend_clr    (pend_clr[g]),
            .count_out   (counts[g*DATAWIDTH_BUS +: DATAWIDTH_BUS]),
            .overflow_out(overflow[g]),
            .pending_out (pending[g])
        );
    end

    // First pending channel at or after the pointer, wrapping.
    logic                     found;
    logic [CHAN_ID_WIDTH-1:0] pick;
    int                       idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = CHAN_ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        wait_d  = wait_q;
        nd_d    = 1'b0;
        data_d  = data_q;
        chan_d  = chan_q;
        case (state_q)
            S_LOCK: begin
                if (!lock) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (lock) begin
                    state_d = S_LOCK;
                end else if (found && !busy) begin
                    grant_d = pick;
                    data_d  = counts[int'(pick)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
                    chan_d  = pick;
                    nd_d    = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                ptr_d   = (int'(grant_q) == NUM_CHANNELS - 1) ? '0 : grant_q + CHAN_ID_WIDTH'(1);
                wait_d  = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Two-cycle floor covers the TX raising txBusy after our strobe.
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (!busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_LOCK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOCK;
            ptr_q   <= '0;
            grant_q <= '0;
            wait_q  <= 1'b0;
            nd_q    <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wait_q  <= wait_d;
            nd_q    <= nd_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign PULSE_COUNTER_MC_newData_Out     = nd_q;
    assign PULSE_COUNTER_MC_data_Out        = data_q;
    assign PULSE_COUNTER_MC_channel_Out     = chan_q;
    assign PULSE_COUNTER_MC_overflow_Out    = overflow;
    assign PULSE_COUNTER_MC_dataCounter_Out = counts;

endmodule

// File: tb/tb_pulse_counter_mc.sv
// Directed bench for pulse_counter_mc: table of per-cycle counting vectors plus
// hand sequences for reporting order, saturation/wrap, txBusy gating and async reset.
module tb_pulse_counter_mc;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   pulse = '0;
    logic [N-1:0]   clr = '0;
    logic           esel = 1'b0;
    logic           sat = 1'b0;
    logic           lock = 1'b0;
    logic           busy = 1'b1;
    logic           nd;
    logic [W-1:0]   data;
    logic [CW-1:0]  chan;
    logic [N-1:0]   ovf;
    logic [N*W-1:0] cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pulse_counter_mc #(
        .NUM_CHANNELS(N), .DATAWIDTH_BUS(W), .CHAN_ID_WIDTH(CW),
        .DEBOUNCE_CYCLES(4), .STATE_SIZE(2)
    ) dut (
        .PULSE_COUNTER_MC_CLOCK_50       (clk),
        .PULSE_COUNTER_MC_RESET_InLow    (rst_n),
        .PULSE_COUNTER_MC_PULSE_InHigh   (pulse),
        .PULSE_COUNTER_MC_CLEAR_InHigh   (clr),
        .PULSE_COUNTER_MC_EDGE_SEL_In    (esel),
        .PULSE_COUNTER_MC_SATURATE_InHigh(sat),
        .PULSE_COUNTER_MC_LOCK_InHigh    (lock),
        .PULSE_COUNTER_MC_txBusy_InHigh  (busy),
        .PULSE_COUNTER_MC_newData_Out    (nd),
        .PULSE_COUNTER_MC_data_Out       (data),
        .PULSE_COUNTER_MC_channel_Out    (chan),
        .PULSE_COUNTER_MC_overflow_Out   (ovf),
        .PULSE_COUNTER_MC_dataCounter_Out(cnt)
    );

    typedef struct {
        logic [N-1:0]   pulse;
        logic [N-1:0]   clr;
        logic           esel;
        logic           lock;
        logic [N*W-1:0] exp_cnt;
        logic [N-1:0]   exp_ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until newData is seen, or 0 on timeout.
    task automatic wait_nd(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (nd === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    int lat;
    int seen;

    initial begin
        // busy held high through the table so only the counters move
        vecs[0]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0000_0100, 4'b0000};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0100, 4'b0000};
        vecs[2]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0000_0200, 4'b0000};
        vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0200, 4'b0000};
        vecs[4]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 32'h0001_0201, 4'b0000};
        vecs[5]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 32'h0001_0201, 4'b0000};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0002_0202, 4'b0000};
        vecs[7]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0002_0202, 4'b0000};
        vecs[8]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 32'h0002_0202, 4'b0000};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0002_0203, 4'b0000};
        vecs[10] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 32'h0002_0203, 4'b0000};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0002_0203, 4'b0000};
        vecs[12] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 32'h0002_0203, 4'b0000};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0002_0203, 4'b0000};
        vecs[14] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0002_0003, 4'b0000};
        vecs[15] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 32'h0002_0000, 4'b0000};

        step();
        chk("rst_newData", 64'(nd), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_channel", 64'(chan), 64'd0);
        chk("rst_overflow", 64'(ovf), 64'd0);
        chk("rst_counters", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 16; v++) begin
            pulse = vecs[v].pulse;
            clr   = vecs[v].clr;
            esel  = vecs[v].esel;
            lock  = vecs[v].lock;
            step();
            chk($sformatf("vec%0d_cnt", v), 64'(cnt), 64'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_ovf", v), 64'(ovf), 64'(vecs[v].exp_ovf));
        end
        pulse = '0; clr = '0; esel = 1'b0; lock = 1'b0;

        // only ch2 is still pending after the clears
        busy = 1'b0;
        wait_nd(8, lat);
        chk("tbl_report_seen", 64'(lat != 0), 64'd1);
        chk("tbl_report_chan", 64'(chan), 64'd2);
        chk("tbl_report_data", 64'(data), 64'd2);
        seen = 0;
        repeat (10) begin step(); if (nd) seen++; end
        chk("tbl_no_stale_report", 64'(seen), 64'd0);

        // three ch1 pulses, each reported separately
        for (int k = 1; k <= 3; k++) begin
            pulse = 4'b0010;
            step();
            pulse = '0;
            wait_nd(8, lat);
            chk($sformatf("ch1_p%0d_seen", k), 64'(lat != 0), 64'd1);
            chk($sformatf("ch1_p%0d_chan", k), 64'(chan), 64'd1);
            chk($sformatf("ch1_p%0d_data", k), 64'(data), 64'(k));
            repeat (4) step();
        end
        chk("ch1_count3", 64'(cnt[1*W +: W]), 64'd3);

        lock = 1'b1;
        seen = 0;
        repeat (5) begin
            pulse = 4'b0010; step(); if (nd) seen++;
            pulse = '0;      step(); if (nd) seen++;
        end
        chk("lock_no_newData", 64'(seen), 64'd0);
        chk("lock_count_held", 64'(cnt[1*W +: W]), 64'd3);
        lock = 1'b0;
        seen = 0;
        repeat (6) begin step(); if (nd) seen++; end
        chk("unlock_no_pending", 64'(seen), 64'd0);

        // simultaneous ch0+ch2 edges from a fresh pointer
        do_reset();
        pulse = 4'b0101;
        step();
        pulse = '0;
        wait_nd(8, lat);
        chk("sim_first_latency", 64'(lat), 64'd1);
        chk("sim_first_chan", 64'(chan), 64'd0);
        chk("sim_first_data", 64'(data), 64'd1);
        wait_nd(8, lat);
        chk("sim_second_gap", 64'(lat), 64'd4);
        chk("sim_second_chan", 64'(chan), 64'd2);
        chk("sim_second_data", 64'(data), 64'd1);

        // saturate then wrap on ch3
        do_reset();
        busy = 1'b1;
        sat  = 1'b1;
        repeat (256) begin
            pulse = 4'b1000; step();
            pulse = '0;      step();
        end
        chk("sat_count", 64'(cnt[3*W +: W]), 64'd255);
        chk("sat_overflow", 64'(ovf), 64'b1000);
        busy = 1'b0;
        wait_nd(8, lat);
        chk("sat_report_seen", 64'(lat != 0), 64'd1);
        chk("sat_report_chan", 64'(chan), 64'd3);
        chk("sat_report_data", 64'(data), 64'd255);
        repeat (4) step();
        sat = 1'b0;
        pulse = 4'b1000;
        step();
        pulse = '0;
        chk("wrap_count", 64'(cnt[3*W +: W]), 64'd0);
        chk("wrap_overflow", 64'(ovf), 64'b1000);
        wait_nd(8, lat);
        chk("wrap_report_seen", 64'(lat != 0), 64'd1);
        chk("wrap_report_data", 64'(data), 64'd0);
        chk("wrap_report_chan", 64'(chan), 64'd3);

        // txBusy gating, then reset asserted while newData is high
        do_reset();
        busy = 1'b1;
        pulse = 4'b0001;
        step();
        pulse = '0;
        seen = 0;
        repeat (10) begin step(); if (nd) seen++; end
        chk("busy_blocks_newData", 64'(seen), 64'd0);
        busy = 1'b0;
        wait_nd(2, lat);
        chk("busy_release_latency", 64'(lat), 64'd1);
        chk("busy_release_data", 64'(data), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_newData", 64'(nd), 64'd0);
        chk("async_rst_data", 64'(data), 64'd0);
        chk("async_rst_channel", 64'(chan), 64'd0);
        chk("async_rst_counters", 64'(cnt), 64'd0);
        chk("async_rst_overflow", 64'(ovf), 64'd0);
        #1;
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_counter_mc.md
Name: pulse_counter_mc

Overview:
- Multi-channel, parametrised successor of the single-channel UART pulse counter.
- Counts edges on NUM_CHANNELS independent pulse inputs, each with its own DATAWIDTH_BUS-bit counter, configurable edge polarity and wrap/saturate overflow handling.
- A round-robin reporter FSM hands each changed count to the UART TX as a one-cycle newData strobe with data and channel ID, gated by txBusy.
- Sits between board pulse sources and the UART_TX data/newData inputs.

Parameters:
- NUM_CHANNELS, 4, number of independent pulse channels (1..16).
- DATAWIDTH_BUS, 8, counter and data_Out width.
- CHAN_ID_WIDTH, 2, width of channel_Out; must be >= clog2(NUM_CHANNELS), minimum 1.
- DEBOUNCE_CYCLES, 4, required stable cycles per input; used only with the macro.
- STATE_SIZE, 2, reporter state register width.

Ports:
- PULSE_COUNTER_MC_CLOCK_50  in  1  system clock, 50 MHz.
- PULSE_COUNTER_MC_RESET_InLow  in  1  asynchronous, active-low reset.
- PULSE_COUNTER_MC_PULSE_InHigh  in  NUM_CHANNELS  pulse inputs, one bit per channel.
- PULSE_COUNTER_MC_CLEAR_InHigh  in  NUM_CHANNELS  synchronous per-channel clear.
- PULSE_COUNTER_MC_EDGE_SEL_In  in  1  0 = count rising edges, 1 = count falling edges.
- PULSE_COUNTER_MC_SATURATE_InHigh  in  1  1 = saturate at max, 0 = wrap.
- PULSE_COUNTER_MC_LOCK_InHigh  in  1  freezes counting and reporting.
- PULSE_COUNTER_MC_txBusy_InHigh  in  1  UART TX busy.
- PULSE_COUNTER_MC_newData_Out  out  1  one-cycle send strobe.
- PULSE_COUNTER_MC_data_Out  out  DATAWIDTH_BUS  reported count.
- PULSE_COUNTER_MC_channel_Out  out  CHAN_ID_WIDTH  reported channel index.
- PULSE_COUNTER_MC_overflow_Out  out  NUM_CHANNELS  sticky per-channel overflow flags.
- PULSE_COUNTER_MC_dataCounter_Out  out  NUM_CHANNELS*DATAWIDTH_BUS  live counters, flattened; channel i occupies bits [i*W +: W].

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Asserting reset, including mid-transfer, immediately clears all registers.
- Reset values: newData 0, data 0, channel 0, overflow 0, all counters 0, all pending flags 0, previous-sample registers 0, round-robin pointer selects channel 0 first, state S_LOCK.
- All outputs are registered.
- Edge detect: per-channel registered previous sample. An edge is prev=0,cur=1 when EDGE_SEL=0, or prev=1,cur=0 when EDGE_SEL=1.
- Counter update, on an edge while LOCK=0:
  - count < max: count+1, pending set.
  - count = max, SATURATE=1: count holds, overflow set, pending unchanged.
  - count = max, SATURATE=0: count wraps to 0, overflow set, pending set.
  - Arithmetic is unsigned, modulo 2^DATAWIDTH_BUS.
- CLEAR[i]: next cycle count, overflow and pending of channel i are 0. CLEAR beats a same-cycle edge on that channel.
- LOCK=1: edges ignored, counts hold, no new grants. A SEND already in progress completes.
- Latency: an edge sampled at clock k is visible in dataCounter at k+1. The earliest newData is at k+2, if the FSM is in S_IDLE and txBusy=0.
- Reporter FSM:
  - S_LOCK: stays while LOCK=1; otherwise goes to S_IDLE.
  - S_IDLE: LOCK=1 goes to S_LOCK. Else, if any pending and txBusy=0, grant the first pending channel at or after the pointer (wrapping), snapshot its count, and go to S_SEND. Otherwise stay.
  - S_SEND (exactly 1 cycle):
    - newData=1; data and channel present the snapshot.
    - Granted channel's pending clears, unless a same-cycle edge on it sets it again (the edge wins).
    - Pointer moves to grant+1, wrapping to 0.
    - Next state is S_WAIT.
  - S_WAIT: minimum 2 cycles (guard for TX busy latency), then goes to S_IDLE on the first cycle txBusy=0.
- data_Out and channel_Out hold their last sent values between sends.
- Simultaneous edges on several channels all count in the same cycle. Reporting is serialised round-robin, so no channel starves.

Optional Feature:
- Macro: PULSE_COUNTER_MC_DEBOUNCE_EN.
- Defined: each input passes through a 2-FF synchronizer and then a stability filter. The filtered level changes only after the synchronised input has been stable for DEBOUNCE_CYCLES consecutive cycles. Edge detection uses the filtered level, adding 2+DEBOUNCE_CYCLES cycles of latency. Filter state resets to 0.
- Undefined: inputs are assumed synchronous and go straight to edge detection; DEBOUNCE_CYCLES is unused.

Decomposition:
- Package pulse_counter_mc_pkg: reporter state encodings S_LOCK=0, S_IDLE=1, S_SEND=2, S_WAIT=3; edge-select constants EDGE_RISE=0, EDGE_FALL=1.
- Sub-module pulse_counter_mc_channel: optional debounce, edge detect, counter, overflow and pending for one channel. Instantiated NUM_CHANNELS times in a generate loop; the top holds the FSM and arbiter.

Test Plan:
- Reset, LOCK=0, txBusy=0, 3 rising pulses on ch1 -> dataCounter ch1=3; three newData strobes with channel=1 and data 1,2,3 (each needs an idle slot).
- Ch0 and ch2 edge in the same cycle, txBusy=0 -> newData (ch0, data 1), then after S_WAIT newData (ch2, data 1).
- SATURATE=1, 256 edges on ch3 -> count 255, overflow[3]=1, last report 255. SATURATE=0 with one more edge from 255 -> count 0, overflow[3]=1, report data 0.
- EDGE_SEL=1, pulse high for 2 cycles then low on ch0 -> exactly one count, on the falling edge.
- LOCK=1 with 5 pulses on ch1 -> count unchanged, no newData. CLEAR[1] with a same-cycle edge -> count 0, pending 0.
- txBusy held high 10 cycles with ch0 pending -> no newData. Release -> newData within 1 cycle of S_IDLE. Reset asserted during S_SEND -> newData drops at once, all outputs 0.
